// File: rtl/sliding_window_stream.sv
// KxK neighbourhood generator for raster video: K-1 line buffers feed a KxK
// register window, emitted with its centre coordinates one cycle after each accept.
module sliding_window_stream #(
    parameter int K        = 3,
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int BUS_SIZE = 24,
    localparam int XW      = $clog2(WIDTH),
    localparam int YW      = $clog2(HEIGHT)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic                                   in_sof,
    input  logic [BUS_SIZE-1:0]                    data,
    output logic                                   out_valid,
    output logic [XW-1:0]                          out_x,
    output logic [YW-1:0]                          out_y,
    output logic [0:K-1][0:K-1][BUS_SIZE-1:0]      dataout
);

    localparam int R = (K - 1) / 2;
    localparam logic [XW-1:0] COL_FIRST = XW'(K - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_OFF     = XW'(R);
    localparam logic [YW-1:0] ROW_FIRST = YW'(K - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_OFF     = YW'(R);

    if ((K % 2) == 0 || K < 3 || WIDTH < K || HEIGHT < K) begin : g_bad_params
        $error("sliding_window_stream: K must be odd and >= 3, WIDTH and HEIGHT >= K");
    end

    logic [XW-1:0]       col;
    logic [YW-1:0]       row;
    logic [XW-1:0]       cur_col;
    logic [YW-1:0]       cur_row;
    logic                interior;
    logic [BUS_SIZE-1:0] new_col [0:K-1];

    // line_buf[0] holds the previous line, line_buf[K-2] the oldest one
    logic [BUS_SIZE-1:0] line_buf [0:K-2][0:WIDTH-1];

    // A start-of-frame pixel is placed at (0,0) whatever the counters say
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        interior = (cur_col >= COL_FIRST) && (cur_row >= ROW_FIRST);
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = line_buf[K-2-r][cur_col];
        end
        new_col[K-1] = data;
    end

    always_ff @(posedge clock) begin
        if (in_valid && !reset) begin
            line_buf[0][cur_col] <= data;
            for (int j = 1; j < K - 1; j++) begin
                line_buf[j][cur_col] <= line_buf[j-1][cur_col];
            end
        end
    end

    // Window shift, registered outputs and raster position counters
    always_ff @(posedge clock) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            dataout   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        dataout[r][c] <= dataout[r][c+1];
                    end
                    dataout[r][K-1] <= new_col[r];
                end
                out_valid <= interior;
                if (interior) begin
                    out_x <= cur_col - X_OFF;
                    out_y <= cur_row - Y_OFF;
                end
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

endmodule

// File: doc/sliding_window_stream.md
Name: sliding_window_stream

Overview:
- Parametrised KxK neighbourhood generator for streaming raster video, successor to the fixed 3-line window used by convolutional_blur.
- Accepts one pixel per valid beat and stores K-1 line buffers of WIDTH pixels plus a KxK register window.
- Emits the full window, its centre coordinates and a window-valid qualifier, so downstream convolution kernels need no position tracking of their own.
- Handles stalls, frame start resync and interior-only validity.

Parameters:
- K, 3: window size. Must be odd and >= 3. R = (K-1)/2.
- WIDTH, 640: pixels per line. Must be >= K.
- HEIGHT, 480: lines per frame. Must be >= K.
- BUS_SIZE, 24: bits per pixel.
- Local XW = $clog2(WIDTH), YW = $clog2(HEIGHT).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel on data is accepted this cycle.
- in_sof  input  1  qualifies the accepted pixel as frame pixel (0,0). Ignored when in_valid=0.
- data  input  BUS_SIZE  pixel, raster order, left to right, top to bottom.
- out_valid  output  1  dataout, out_x and out_y hold a complete interior window.
- out_x  output  XW  centre column of the window.
- out_y  output  YW  centre row of the window.
- dataout  output  BUS_SIZE x [0:K-1][0:K-1]  window. dataout[r][c] = pixel(out_x-R+c, out_y-R+r); r=0 is the top row, c=0 is the left column.

Behaviour:
- Reset (sync, reset=1 at a clock edge):
  - col and row counters go to 0.
  - out_valid=0, out_x=0, out_y=0, all dataout entries 0.
  - Line buffer storage is not cleared. Its stale contents are masked by the validity rule.
  - Reset overrides in_valid in the same cycle: the pixel is dropped.
- Accept (in_valid=1):
  - If in_sof=1, the pixel is treated as (0,0) regardless of the counter state.
  - Otherwise the pixel is at the current (col,row).
  - The window shifts left by one column. The new right column is the K-1 line-buffer taps (oldest row at r=0) plus data at r=K-1.
  - Line buffers advance by one.
  - Counters: col increments. At col=WIDTH-1, col wraps to 0 and row increments. At (WIDTH-1,HEIGHT-1) both wrap to 0, so a next frame without in_sof continues correctly.
- Latency: exactly 1 cycle from the accepting edge to the registered outputs.
  - out_valid=1 iff the accepted pixel had col >= K-1 and row >= K-1.
  - In that case out_x = col-R and out_y = row-R.
- Left-edge rule: windows never straddle a line wrap, because validity requires col >= K-1.
- Stall (in_valid=0):
  - No shift and no counter change.
  - out_valid=0 on the next cycle.
  - dataout, out_x and out_y hold their last values.
- Mid-frame in_sof: resynchronises the counters to (0,0). Output stays invalid until row and col again reach K-1, so no window mixes data across frames.
- Border pixels (centre within R of any edge) produce no output.
- Output count per frame: (WIDTH-2R)*(HEIGHT-2R) windows.
- Stall independence: the out_valid=1 count and order depend only on accepted pixels, not on the stall pattern.
- Implementation:
  - Line buffers may be inferred RAM, one read and one write per accept, with the read-before-write result used.
  - Total storage: (K-1)*WIDTH*BUS_SIZE bits plus the K*K window registers.
- Synthesis: an elaboration-time check rejects even K, WIDTH < K and HEIGHT < K.

Test Plan:
- Basic window. Config: K=3, WIDTH=8, HEIGHT=6, BUS_SIZE=8. Stimulus: continuous frame, pixel = row*16+col, in_sof on the first pixel. Expected:
  - The first out_valid follows acceptance of pixel 0x22 by 1 cycle, with out_x=1, out_y=1.
  - dataout[0][0]=0x00, [1][1]=0x11, [2][2]=0x22, [0][2]=0x02, [2][0]=0x20.
  - Exactly 24 valid windows, the last at (6,4) with [2][2]=0x57.
- Random stalls. Same frame with in_valid held low on about 40% of cycles. Expected: an identical sequence of 24 (out_x, out_y, dataout) tuples, and out_valid is never high in the cycle after a stall.
- Mid-frame resync. in_sof asserted at input (3,2) of frame 1, then a full frame follows. Expected:
  - No out_valid until the new frame's pixel (2,2) is accepted.
  - The next window is at (1,1) and contains new-frame data only.
- Reset mid-operation. Assert reset for 1 cycle after 20 accepts while in_valid=1. Expected:
  - The next cycle shows out_valid=0 and dataout all 0.
  - The pixel presented during reset is dropped.
  - A fresh frame then produces the Basic window results exactly.
- Back-to-back frames without in_sof. Two frames streamed consecutively. Expected: 48 valid windows, and the second frame's first window is at (1,1) with [1][1]=0x11.
- Larger K. Config: K=5, WIDTH=16, HEIGHT=8. Expected:
  - First window at (2,2), with dataout[0][0]=0x00 and [4][4]=0x44.
  - 12*4 = 48 windows total.
